// File: rtl/serdes_ctrl_pkg.sv
// serdes_ctrl_pkg: state encoding and descriptor validation shared by serdes_ctrl
// and the scheduler's descriptor generator.
package serdes_ctrl_pkg;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;
    function automatic logic desc_ok(input int unsigned num_words, input int unsigned count,
                                     input int unsigned last_count, input int unsigned out_words,
                                     input int unsigned in_count);
        return num_words != 0 && out_words != 0 && count != 0 && count <= in_count &&
               last_count != 0 && last_count <= in_count;
    endfunction
endpackage

// File: rtl/serdes_ctrl.sv
// serdes_ctrl: sequences one tile through the serdes packer, flushing the tail
// word unless the tile is passthrough, and counting packed output words to completion.
module serdes_ctrl
    import serdes_ctrl_pkg::*;
#(
    parameter int IN_COUNT = 10,
    parameter int OP_WIDTH = 16,
    parameter int IN_WIDTH = IN_COUNT * OP_WIDTH,
    parameter int COUNT_W  = $clog2(IN_COUNT + 1),
    parameter int LEN_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [LEN_W-1:0]    cfg_num_words,
    input  logic [COUNT_W-1:0]  cfg_count,
    input  logic [COUNT_W-1:0]  cfg_last_count,
    input  logic [LEN_W-1:0]    cfg_out_words,
    input  logic                src_valid,
    output logic                src_ready,
    input  logic [IN_WIDTH-1:0] src_data,
    output logic                sd_write_req,
    input  logic                sd_write_ready,
    output logic [IN_WIDTH-1:0] sd_write_data,
    output logic [COUNT_W-1:0]  sd_count,
    output logic                sd_write_flush,
    input  logic                sd_out_req,
    output logic                busy,
    output logic                done,
    output logic                err
);
    logic [1:0]         state_q, state_d;
    logic [LEN_W-1:0]   words_left_q, words_left_d, out_seen_q, out_seen_d, out_words_q, out_words_d;
    logic [COUNT_W-1:0] count_q, count_d, last_count_q, last_count_d;
    logic               done_q, done_d, err_q, err_d;
    logic               issue, xfer, last_xfer, passthru, cfg_ok, accept, out_take, overrun, drained;

    assign cfg_ok    = desc_ok(32'(cfg_num_words), 32'(cfg_count), 32'(cfg_last_count),
                               32'(cfg_out_words), 32'(IN_COUNT));
    assign accept    = state_q == IDLE && cfg_valid && cfg_ok;
    assign issue     = state_q == ISSUE;
    assign xfer      = issue && src_valid && sd_write_ready;
    assign last_xfer = xfer && words_left_q == LEN_W'(1);
    assign passthru  = count_q == COUNT_W'(IN_COUNT) && last_count_q == COUNT_W'(IN_COUNT);
    // out_seen never exceeds the descriptor; a surplus word raises err instead
    assign out_take  = sd_out_req && state_q != IDLE;
    assign overrun   = out_take && out_seen_q >= out_words_q;
    assign drained   = state_q == DRAIN && out_seen_q == out_words_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            words_left_q <= '0;
            out_seen_q   <= '0;
            out_words_q  <= '0;
            count_q      <= '0;
            last_count_q <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            out_seen_q   <= out_seen_d;
            out_words_q  <= out_words_d;
            count_q      <= count_d;
            last_count_q <= last_count_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? ISSUE : IDLE;
            ISSUE:   state_d = last_xfer ? (passthru ? DRAIN : FLUSH) : ISSUE;
            FLUSH:   state_d = DRAIN;
            default: state_d = drained ? IDLE : DRAIN;
        endcase
    end

    always_comb begin
        count_d      = accept ? cfg_count : count_q;
        last_count_d = accept ? cfg_last_count : last_count_q;
        out_words_d  = accept ? cfg_out_words : out_words_q;
        words_left_d = accept ? cfg_num_words :
                       (xfer && words_left_q != '0) ? words_left_q - LEN_W'(1) : words_left_q;
        out_seen_d   = accept ? '0 : (out_take && !overrun) ? out_seen_q + LEN_W'(1) : out_seen_q;
        err_d        = (state_q == IDLE && cfg_valid && !cfg_ok) || overrun;
        done_d       = drained;
    end

    always_comb begin
        cfg_ready      = state_q == IDLE;
        src_ready      = issue && sd_write_ready;
        sd_write_req   = xfer;
        sd_write_data  = issue ? src_data : '0;
        sd_count       = issue ? (words_left_q == LEN_W'(1) ? last_count_q : count_q) : '0;
        sd_write_flush = state_q == FLUSH;
        busy           = state_q != IDLE;
        done           = done_q;
        err            = err_q;
    end
endmodule

// File: tb/tb_serdes_ctrl.sv
// tb_serdes_ctrl: scoreboard bench for serdes_ctrl; expected writes are queued as
// words are offered upstream and matched against each serdes write.
module tb_serdes_ctrl;
    localparam int IN_COUNT = 10;
    localparam int IN_WIDTH = 160;
    localparam int COUNT_W  = 4;
    localparam int LEN_W    = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                cfg_valid, cfg_ready;
    logic [LEN_W-1:0]    cfg_num_words, cfg_out_words;
    logic [COUNT_W-1:0]  cfg_count, cfg_last_count;
    logic                src_valid, src_ready;
    logic [IN_WIDTH-1:0] src_data;
    logic                sd_write_req, sd_write_ready, sd_write_flush, sd_out_req;
    logic [IN_WIDTH-1:0] sd_write_data;
    logic [COUNT_W-1:0]  sd_count;
    logic                busy, done, err;

    typedef struct packed {
        logic [IN_WIDTH-1:0] data;
        logic [COUNT_W-1:0]  cnt;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int flush_cnt, done_cnt, err_cnt;

    always #5 clk = ~clk;

    serdes_ctrl dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_num_words(cfg_num_words), .cfg_count(cfg_count),
        .cfg_last_count(cfg_last_count), .cfg_out_words(cfg_out_words),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .sd_write_req(sd_write_req), .sd_write_ready(sd_write_ready),
        .sd_write_data(sd_write_data), .sd_count(sd_count),
        .sd_write_flush(sd_write_flush), .sd_out_req(sd_out_req),
        .busy(busy), .done(done), .err(err)
    );

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sd_write_req) begin
            if (exp_q.size() == 0) check("unexpected_write", 1, 0);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_data", sd_write_data, e.data);
                check("wr_count", sd_count, e.cnt);
                check("wr_ready", sd_write_ready, 1);
            end
        end
        if (sd_write_flush) begin
            flush_cnt++;
            check("flush_after_writes", exp_q.size(), 0);
        end
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    task automatic send_cfg(input int words, input int cnt, input int last, input int out);
        int t = 0;
        @(negedge clk);
        while (!cfg_ready && t < 50) begin @(negedge clk); t++; end
        if (!cfg_ready) check("cfg_ready_timeout", 0, 1);
        cfg_num_words = LEN_W'(words);
        cfg_count = COUNT_W'(cnt);
        cfg_last_count = COUNT_W'(last);
        cfg_out_words = LEN_W'(out);
        cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic feed(input int n_send, input int words, input int cnt, input int last, input int bp_at);
        for (int i = 0; i < n_send; i++) begin
            int t = 0;
            exp_t e;
            src_data = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            src_valid = 1'b1;
            e.data = src_data;
            e.cnt = COUNT_W'(i == words - 1 ? last : cnt);
            exp_q.push_back(e);
            if (i == bp_at) begin
                sd_write_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_src_ready", src_ready, 0);
                    check("bp_write_req", sd_write_req, 0);
                end
                @(posedge clk); #1;
                sd_write_ready = 1'b1;
            end
            @(negedge clk);
            while (!src_ready && t < 50) begin @(negedge clk); t++; end
            if (!src_ready) check("src_timeout", 0, 1);
            @(posedge clk); #1;
        end
        src_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!done && lat < 20);
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic run_tile(input int words, input int cnt, input int last, input int out,
                            input int bp_at, input string tag);
        int lat;
        flush_cnt = 0; done_cnt = 0; err_cnt = 0;
        send_cfg(words, cnt, last, out);
        check({tag, "_busy"}, busy, 1);
        feed(words, words, cnt, last, bp_at);
        for (int k = 0; k < out; k++) begin
            check({tag, "_no_early_done"}, done_cnt, 0);
            sd_out_req = 1'b1;
            @(posedge clk); #1;
            sd_out_req = 1'b0;
            if (k < out - 1) begin @(posedge clk); #1; end
        end
        wait_done(lat);
        check({tag, "_done_latency"}, lat, 2);
        check({tag, "_cfg_ready_at_done"}, cfg_ready, 1);
        @(posedge clk); #1;
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_flush_cnt"}, flush_cnt, (cnt == IN_COUNT && last == IN_COUNT) ? 0 : 1);
        check({tag, "_err_cnt"}, err_cnt, 0);
        check({tag, "_all_written"}, exp_q.size(), 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int lat;
        reset = 1'b0; cfg_valid = 1'b0; cfg_num_words = '0; cfg_count = '0;
        cfg_last_count = '0; cfg_out_words = '0; src_valid = 1'b0; src_data = '0;
        sd_write_ready = 1'b1; sd_out_req = 1'b0;
        flush_cnt = 0; done_cnt = 0; err_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_write_req", sd_write_req, 0);
        check("rst_flush", sd_write_flush, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        run_tile(3, 4, 2, 1, -1, "basic");
        run_tile(2, 10, 10, 2, -1, "passthru");
        run_tile(4, 5, 3, 1, 2, "backpressure");

        for (int b = 0; b < 3; b++) begin
            err_cnt = 0;
            case (b)
                0: send_cfg(3, 0, 2, 1);
                1: send_cfg(3, 11, 2, 1);
                default: send_cfg(0, 4, 2, 1);
            endcase
            @(negedge clk);
            check("bad_err_pulse", err, 1);
            check("bad_cfg_ready", cfg_ready, 1);
            check("bad_busy", busy, 0);
            @(negedge clk);
            check("bad_err_clears", err, 0);
            check("bad_stays_idle", busy, 0);
        end

        flush_cnt = 0; done_cnt = 0; err_cnt = 0;
        send_cfg(1, 4, 4, 1);
        feed(1, 1, 4, 4, -1);
        @(posedge clk); #1;
        sd_out_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        sd_out_req = 1'b0;
        wait_done(lat);
        check("ovr_done_latency", lat, 1);
        check("ovr_err_with_done", err, 1);
        @(posedge clk); #1;
        check("ovr_err_cnt", err_cnt, 1);
        check("ovr_done_cnt", done_cnt, 1);

        done_cnt = 0;
        send_cfg(4, 4, 4, 1);
        feed(2, 4, 4, 4, -1);
        check("mid_busy_before_rst", busy, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cfg_ready", cfg_ready, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_no_done", done_cnt, 0);
        run_tile(3, 4, 2, 1, -1, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serdes_ctrl.md
Name: serdes_ctrl

Overview:
- Sequences one tile of traffic through the `serdes` packer.
- Accepts a tile descriptor: word count, per-word operand count, last-word operand count, expected output words.
- Streams input words from an upstream buffer into `serdes` with the correct per-word `count`.
- Issues the end-of-tile flush, then tracks packed output words until the tile completes and reports done/error to the layer scheduler.

Parameters:
- IN_COUNT, 10, operands per input word; must match the serdes instance.
- OP_WIDTH, 16, operand width in bits.
- IN_WIDTH, IN_COUNT*OP_WIDTH, input word width.
- COUNT_W, C_LOG_2(IN_COUNT+1), width of per-word count fields.
- LEN_W, 16, width of word-count fields.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- cfg_valid  input  1  descriptor valid
- cfg_ready  output  1  controller idle, accepts descriptor
- cfg_num_words  input  LEN_W  input words in tile
- cfg_count  input  COUNT_W  operands per word, all but last
- cfg_last_count  input  COUNT_W  operands in last word
- cfg_out_words  input  LEN_W  packed words expected from serdes
- src_valid  input  1  upstream word valid
- src_ready  output  1  upstream word accepted
- src_data  input  IN_WIDTH  upstream word
- sd_write_req  output  1  to serdes s_write_req
- sd_write_ready  input  1  from serdes s_write_ready
- sd_write_data  output  IN_WIDTH  to serdes s_write_data
- sd_count  output  COUNT_W  to serdes count
- sd_write_flush  output  1  to serdes s_write_flush
- sd_out_req  input  1  monitor of serdes m_write_req
- busy  output  1  tile in progress
- done  output  1  one-cycle pulse, tile complete
- err  output  1  one-cycle pulse, bad descriptor or output overrun

Behaviour:
- Reset, asynchronous active-low: state IDLE, all counters 0. Outputs: cfg_ready=1, all others 0.
- Reset mid-tile aborts the tile with no done pulse.
- States: IDLE, ISSUE, FLUSH, DRAIN.
- IDLE:
  - cfg_ready=1. On cfg_valid, latch the descriptor.
  - Reject if any of: cfg_num_words==0; cfg_count or cfg_last_count equal to 0 or greater than IN_COUNT; cfg_out_words==0.
  - Reject: err=1 next cycle, stay IDLE. Accept: words_left<=cfg_num_words, out_seen<=0, go to ISSUE.
- ISSUE:
  - Combinational signals:
    - src_ready = sd_write_ready.
    - sd_write_req = src_valid & sd_write_ready.
    - sd_write_data = src_data.
    - sd_count = (words_left==1) ? last_count : count.
  - Each transfer decrements words_left.
  - On the transfer with words_left==1: go to DRAIN if passthrough, else to FLUSH.
  - Passthrough means count==IN_COUNT and last_count==IN_COUNT.
- FLUSH: sd_write_flush=1 for exactly one cycle, sd_write_req=0, then go to DRAIN.
- DRAIN: wait for out_seen==cfg_out_words. Then done=1 for one cycle, go to IDLE. cfg_ready returns the same cycle done pulses.
- out_seen:
  - Increments on sd_out_req in ISSUE, FLUSH and DRAIN, including the same cycle as the final input transfer. Ignored in IDLE.
  - If an increment would make out_seen exceed cfg_out_words: err pulses, the extra word is not counted, and the tile still completes on the normal condition.
- busy = state!=IDLE.
- sd_write_req is never asserted when sd_write_ready=0, so no write is dropped on serdes full.
- Saturation: words_left and out_seen do not wrap (LEN_W-bit, compared before increment).

Decomposition:
- Package serdes_ctrl_pkg holds:
  - the state encoding localparams (IDLE=0, ISSUE=1, FLUSH=2, DRAIN=3);
  - the descriptor-check function, shared with the scheduler's descriptor generator.
- words_left and out_seen are simple registers; no sub-module beyond the existing `counter`, which may be reused for out_seen.
- Target size is about 180 RTL lines.

Test Plan:
- Descriptor words=3, count=4, last=2, out=1 (IN_COUNT=10), src always valid, serdes ready → sd_count sequence 4,4,2; one flush pulse after the third write; done after 1 sd_out_req.
- Passthrough: words=2, count=10, last=10, out=2 → no sd_write_flush; done after the 2nd sd_out_req; sd_write_data equals src_data.
- Backpressure: sd_write_ready low for 5 cycles mid-tile → src_ready=0, sd_write_req=0 throughout, no data lost, words_left unchanged.
- Bad descriptors, each expecting err pulse, cfg_ready stays 1, busy stays 0:
  - count=0;
  - count=11;
  - words=0.
- Overrun: out=1 but 2 sd_out_req pulses in DRAIN → done after the first, err on the second (same cycle if simultaneous).
- reset low during ISSUE with words_left=2 → busy=0, cfg_ready=1 immediately; no done; next descriptor runs normally.
